// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment display path.
// Segment patterns are active low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  localparam logic [15:0][6:0] SEG_LUT = {
    7'h0E, 7'h06, 7'h21, 7'h46,
    7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19,
    7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low seven-segment pattern.
// Pattern table lives in seg7_pkg.
import seg7_pkg::*;

module hex_to_seg7 (
  input  logic [3:0] nib,
  output logic [6:0] seg_n
);

  assign seg_n = SEG_LUT[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scan driver with per-frame shadow latch and ghost gap.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits at shadow load.
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 100000,
  parameter int GHOST_TICKS = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_start
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] LAST_TICK = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] GHOST     = CW'(GHOST_TICKS);

  localparam logic [NUM_DIGITS-1:0] AN_ALL = AN_OFF[NUM_DIGITS-1:0];

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic          load_pending;

  logic [NUM_DIGITS-1:0][3:0] sh_val;
  logic [NUM_DIGITS-1:0]      sh_dp;
  logic [NUM_DIGITS-1:0]      sh_en;

  logic [NUM_DIGITS-1:0][3:0] val_w;
  logic [NUM_DIGITS-1:0]      en_ld;
  logic [NUM_DIGITS-1:0]      an_next;
  logic [6:0]                 seg_w;
  logic                       slot_end;
  logic                       load;

  assign val_w    = value;
  assign slot_end = (cnt == LAST_TICK);
  assign load     = load_pending | (slot_end & (idx == LAST_IDX));

`ifdef SEG7_LZ_BLANK_EN
  logic lead;

  // Walk down from the top digit; digit 0 is never blanked.
  always_comb begin
    en_ld = digit_en;
    lead  = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (lead && val_w[i] == 4'h0 && !dp_mask[i])
        en_ld[i] = 1'b0;
      else
        lead = 1'b0;
    end
  end
`else
  assign en_ld = digit_en;
`endif

  hex_to_seg7 u_dec (
    .nib   (sh_val[idx]),
    .seg_n (seg_w)
  );

  always_comb begin
    an_next = AN_ALL;
    if (cnt >= GHOST && sh_en[idx])
      an_next = ~(NUM_DIGITS'(1) << idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      idx          <= '0;
      load_pending <= 1'b1;
      sh_val       <= '0;
      sh_dp        <= '0;
      sh_en        <= '0;
      an_n         <= AN_ALL;
      seg_n        <= SEG_OFF;
      dp_n         <= 1'b1;
      frame_start  <= 1'b0;
    end else begin
      load_pending <= 1'b0;
      frame_start  <= load;
      an_n         <= an_next;
      seg_n        <= seg_w;
      dp_n         <= ~sh_dp[idx];
      if (slot_end) begin
        cnt <= '0;
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (load) begin
        sh_val <= val_w;
        sh_dp  <= dp_mask;
        sh_en  <= en_ld;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a time-indexed display model.
// Optional SEG7_LZ_BLANK_EN is mirrored in the model when defined.
module tb_seg7_scan_driver;

  localparam int N   = 4;
  localparam int DT  = 8;
  localparam int G   = 2;
  localparam int TOT = N * DT;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_mask = '0;
  logic [3:0]    digit_en = '0;
  logic [3:0]    an_n;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic          frame_start;

  int n_checks = 0;
  int n_errors = 0;
  int e = 0;

  logic [15:0] s_val = '0;
  logic [3:0]  s_dp  = '0;
  logic [3:0]  s_en  = '0;
  logic [3:0]  x_an;
  logic [6:0]  x_seg;
  logic        x_dp;
  logic        x_fs;
  int          x_tick;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                           7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                           7'h46, 7'h21, 7'h06, 7'h0E};

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .DIGIT_TICKS (DT),
    .GHOST_TICKS (G)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .value       (value),
    .dp_mask     (dp_mask),
    .digit_en    (digit_en),
    .an_n        (an_n),
    .seg_n       (seg_n),
    .dp_n        (dp_n),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, e, got, exp);
    end
  endtask

  function automatic logic [3:0] eff_en(input logic [15:0] v,
                                        input logic [3:0] dp,
                                        input logic [3:0] en);
    logic [3:0] r;
    r = en;
`ifdef SEG7_LZ_BLANK_EN
    for (int d = 3; d >= 1; d--) begin
      if (v[4*d +: 4] != 4'h0 || dp[d]) break;
      r[d] = 1'b0;
    end
`endif
    return r;
  endfunction

  // Outputs after edge e show the scan position e-1 clocks after release,
  // using the snapshot taken at the most recent frame boundary.
  task automatic run(input int n);
    int t;
    int slot;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      e++;
      t      = e - 1;
      slot   = (t / DT) % N;
      x_tick = t % DT;
      x_seg  = tbl[s_val[4*slot +: 4]];
      x_dp   = ~s_dp[slot];
      x_an   = 4'hF;
      if (x_tick >= G && s_en[slot]) x_an[slot] = 1'b0;
      x_fs   = (e == 1) || (e % TOT == 0);
      if (x_fs) begin
        s_val = value;
        s_dp  = dp_mask;
        s_en  = eff_en(value, dp_mask, digit_en);
      end
      @(negedge clk);
      check("an_n", 32'(an_n), 32'(x_an));
      check("seg_n", 32'(seg_n), 32'(x_seg));
      check("dp_n", 32'(dp_n), 32'(x_dp));
      check("frame_start", 32'(frame_start), 32'(x_fs));
      check("onehot0", 32'($countones(~an_n) <= 1), 32'd1);
      if (x_tick < G) check("ghost", 32'(an_n), 32'hF);
    end
  endtask

  task automatic check_reset_vals();
    check("rst_an", 32'(an_n), 32'hF);
    check("rst_seg", 32'(seg_n), 32'h7F);
    check("rst_dp", 32'(dp_n), 32'd1);
    check("rst_fs", 32'(frame_start), 32'd0);
  endtask

  task automatic release_reset();
    e     = 0;
    s_val = '0;
    s_dp  = '0;
    s_en  = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    value    = 16'h1A80;
    digit_en = 4'hF;
    dp_mask  = 4'h0;
    #12;
    check_reset_vals();
    release_reset();
    run(2 * TOT);

    // Change mid-frame, during digit 2 of the current frame.
    run(2 * DT + 3);
    value = 16'hFFFF;
    run(2 * TOT);

    digit_en = 4'b0101;
    dp_mask  = 4'b0001;
    value    = 16'h0005;
    run(2 * TOT);

    value    = 16'h0000;
    digit_en = 4'hF;
    dp_mask  = 4'h0;
    run(TOT);

    value = 16'h0300;
    run(TOT);

    // Async reset at tick 5 of digit 2.
    while (e % TOT != 2 * DT + 5) run(1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals();
    #20 check_reset_vals();
    value = 16'h9C2E;
    release_reset();
    run(TOT + 5);

    for (int r = 0; r < 24; r++) begin
      run($urandom_range(1, 20));
      value    = 16'($urandom);
      dp_mask  = 4'($urandom);
      digit_en = 4'($urandom);
      if (r % 4 == 0) value = {4'h0, 4'($urandom_range(0, 1)), 8'($urandom)};
    end
    run(3 * TOT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
